// File: rtl/xor_stream_descrambler_if.sv
// Stream bundle for xor_stream_descrambler: serial bit input, byte output, status flags.
// parity_err exists only when DESCRAMBLER_PARITY_EN is defined.
interface xor_stream_descrambler_if;
  // in_valid marks a bit with no backpressure. A byte is transferred on any rising
  // edge where out_valid and out_ready are both high. out_valid never drops without
  // such a transfer, and out_byte is stable while out_valid is high.
  logic       in_valid;
  logic       in_bit;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_byte;
  logic       locked;
  logic       overflow;
  logic       dbg_state;
`ifdef DESCRAMBLER_PARITY_EN
  logic       parity_err;
`endif

  modport master (
    output in_valid, in_bit, out_ready,
    input  out_valid, out_byte, locked, overflow, dbg_state
`ifdef DESCRAMBLER_PARITY_EN
    , input parity_err
`endif
  );

  modport slave (
    input  in_valid, in_bit, out_ready,
    output out_valid, out_byte, locked, overflow, dbg_state
`ifdef DESCRAMBLER_PARITY_EN
    , output parity_err
`endif
  );
endinterface

// File: rtl/xor_stream_descrambler.sv
// Self-synchronising descrambler (x^LFSR_LEN + x^TAP + 1) with LSB-first byte assembly
// into a one-entry valid/ready output register. Optional feature: DESCRAMBLER_PARITY_EN.
module xor_stream_descrambler #(
  parameter int LFSR_LEN = 7,
  parameter int TAP      = 4
) (
  input logic                     clk,
  input logic                     reset,
  xor_stream_descrambler_if.slave io_bus
);
`ifdef DESCRAMBLER_PARITY_EN
  localparam int             BCW      = 4;
  localparam int             AW       = 8;
  localparam logic [BCW-1:0] LAST_BIT = 4'd8;
`else
  localparam int             BCW      = 3;
  localparam int             AW       = 7;
  localparam logic [BCW-1:0] LAST_BIT = 3'd7;
`endif
  localparam int SCW = $clog2(LFSR_LEN);

  typedef enum logic {SYNC = 1'b0, RUN = 1'b1} state_t;

  state_t            r_state;
  logic [LFSR_LEN-1:0] r_hist;
  logic [SCW-1:0]    r_sync_cnt;
  logic [BCW-1:0]    r_bit_cnt;
  logic [AW-1:0]     r_asm;
  logic              r_out_valid;
  logic [7:0]        r_out_byte;
  logic              r_locked;
  logic              r_overflow;

  logic              w_d;
  logic              w_last;
  logic              w_load;
  logic [7:0]        w_byte;

  // hist holds raw line bits, so the descrambler re-synchronises after any bit error
  assign w_d    = io_bus.in_bit ^ r_hist[LFSR_LEN-1] ^ r_hist[TAP-1];
  assign w_last = (r_state == RUN) && io_bus.in_valid && (r_bit_cnt == LAST_BIT);
  assign w_load = w_last && (!r_out_valid || io_bus.out_ready);

`ifdef DESCRAMBLER_PARITY_EN
  logic w_perr;
  logic r_parity_err;
  assign w_byte            = r_asm;
  assign w_perr            = (^r_asm) ^ w_d;
  assign io_bus.parity_err = r_parity_err;

  always_ff @(posedge clk) begin
    if (reset)       r_parity_err <= 1'b0;
    else if (w_load) r_parity_err <= w_perr;
  end
`else
  assign w_byte = {w_d, r_asm};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= SYNC;
      r_hist      <= '0;
      r_sync_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_asm       <= '0;
      r_out_valid <= 1'b0;
      r_out_byte  <= 8'h00;
      r_locked    <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (r_out_valid && io_bus.out_ready) r_out_valid <= 1'b0;
      if (io_bus.in_valid) begin
        r_hist <= {r_hist[LFSR_LEN-2:0], io_bus.in_bit};
        case (r_state)
          SYNC: begin
            r_sync_cnt <= r_sync_cnt + SCW'(1);
            if (r_sync_cnt == SCW'(LFSR_LEN - 1)) begin
              r_state  <= RUN;
              r_locked <= 1'b1;
            end
          end
          RUN: begin
            if (w_last) begin
              r_bit_cnt <= '0;
              if (w_load) begin
                r_out_byte  <= w_byte;
                r_out_valid <= 1'b1;
              end else begin
                r_overflow <= 1'b1;
              end
            end else begin
              r_asm[r_bit_cnt[2:0]] <= w_d;
              r_bit_cnt             <= r_bit_cnt + BCW'(1);
            end
          end
          default: r_state <= SYNC;
        endcase
      end
    end
  end

  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_byte  = r_out_byte;
  assign io_bus.locked    = r_locked;
  assign io_bus.overflow  = r_overflow;
  assign io_bus.dbg_state = (r_state == RUN);
endmodule

// File: tb/tb_xor_stream_descrambler.sv
// Bench for xor_stream_descrambler: directed test-plan sequences plus random traffic,
// checked every cycle against a bit-history model of the descrambler.
module tb_xor_stream_descrambler;
  localparam int L = 7;
  localparam int T = 4;
`ifdef DESCRAMBLER_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  xor_stream_descrambler_if bus();

  xor_stream_descrambler #(.LFSR_LEN(L), .TAP(T)) dut (
    .clk   (clk),
    .reset (reset),
    .io_bus(bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // model: every accepted raw bit since reset, plus the registered outputs it implies
  bit         raw_q[$];
  logic [8:0] m_frame;
  logic       m_valid, m_locked, m_over, m_perr;
  logic [7:0] m_byte;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    raw_q.delete();
    exp_q.delete();
    m_frame  = '0;
    m_valid  = 1'b0;
    m_locked = 1'b0;
    m_over   = 1'b0;
    m_perr   = 1'b0;
    m_byte   = 8'h00;
  endtask

  task automatic model_update(input logic rst, input logic v, input logic b, input logic rdy);
    logic load;
    int   n, k;
    logic d;
    load = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    if (v) begin
      raw_q.push_back(b);
      n = raw_q.size() - 1;
      if (n == L - 1) m_locked = 1'b1;
      if (n >= L) begin
        d = b ^ raw_q[n-L] ^ raw_q[n-T];
        k = (n - L) % FRAME;
        m_frame[k] = d;
        if (k == FRAME - 1) begin
          if (!m_valid || rdy) begin
            load   = 1'b1;
            m_byte = m_frame[7:0];
            m_perr = ^m_frame[FRAME-1:0];
            exp_q.push_back(m_byte);
          end else begin
            m_over = 1'b1;
          end
        end
      end
    end
    if (load) m_valid = 1'b1;
    else if (m_valid && rdy) m_valid = 1'b0;
  endtask

  task automatic compare_all();
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("out_byte",  32'(bus.out_byte),  32'(m_byte));
    chk("locked",    32'(bus.locked),    32'(m_locked));
    chk("overflow",  32'(bus.overflow),  32'(m_over));
    chk("dbg_state", 32'(bus.dbg_state), 32'(m_locked));
`ifdef DESCRAMBLER_PARITY_EN
    chk("parity_err", 32'(bus.parity_err), 32'(m_perr));
`endif
  endtask

  // drive one cycle, score any transfer, advance the model, compare on the falling edge
  task automatic step(input logic rst, input logic v, input logic b, input logic rdy);
    logic [7:0] e;
    reset         = rst;
    bus.in_valid  = v;
    bus.in_bit    = b;
    bus.out_ready = rdy;
    #1;
    if (!rst && bus.out_valid && rdy) begin
      if (exp_q.size() == 0) begin
        chk("consumed_unexpected", 32'(bus.out_byte), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("consumed_byte", 32'(bus.out_byte), 32'(e));
      end
    end
    @(posedge clk);
    model_update(rst, v, b, rdy);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_zeros(input int cnt, input int gap, input logic rdy);
    for (int i = 0; i < cnt; i++) begin
      repeat (gap) step(1'b0, 1'b0, 1'b0, rdy);
      step(1'b0, 1'b1, 1'b0, rdy);
    end
  endtask

  // raw bits 1,0,1,0,1,1,1,0 after 7 zeros descramble to 8'hA5; a 9th raw 1 gives even parity
  task automatic send_a5(input int nbits, input int gap, input logic rdy, input logic p9);
    logic [7:0] seq;
    seq = 8'b0111_0101;
    for (int i = 0; i < nbits && i < 8; i++) begin
      repeat (gap) step(1'b0, 1'b0, 1'b0, rdy);
      step(1'b0, 1'b1, seq[i], rdy);
    end
    if (nbits >= 8 && FRAME == 9) begin
      repeat (gap) step(1'b0, 1'b0, 1'b0, rdy);
      step(1'b0, 1'b1, p9, rdy);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();

    // reset state
    do_reset();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_byte",  32'(bus.out_byte),  32'h00);
    chk("rst_locked",    32'(bus.locked),    32'd0);
    chk("rst_overflow",  32'(bus.overflow),  32'd0);

    // lock after exactly L bits, then an all-zero frame
    send_zeros(L - 1, 0, 1'b0);
    chk("lock_early", 32'(bus.locked), 32'd0);
    send_zeros(1, 0, 1'b0);
    chk("lock_rise", 32'(bus.locked), 32'd1);
    chk("lock_no_valid", 32'(bus.out_valid), 32'd0);
    send_zeros(FRAME - 1, 0, 1'b0);
    chk("zero_not_yet", 32'(bus.out_valid), 32'd0);
    send_zeros(1, 0, 1'b0);
    chk("zero_valid", 32'(bus.out_valid), 32'd1);
    chk("zero_byte",  32'(bus.out_byte),  32'h00);

    // A5 with consumer always ready: single-cycle valid pulse
    do_reset();
    send_zeros(L, 0, 1'b1);
    send_a5(8, 0, 1'b1, 1'b1);
    chk("a5_byte",  32'(bus.out_byte),  32'hA5);
    chk("a5_valid", 32'(bus.out_valid), 32'd1);
`ifdef DESCRAMBLER_PARITY_EN
    chk("a5_par_ok", 32'(bus.parity_err), 32'd0);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("a5_pulse_end", 32'(bus.out_valid), 32'd0);

    // overflow: second byte dropped while the first is held
    do_reset();
    send_zeros(L, 0, 1'b0);
    send_a5(8, 0, 1'b0, 1'b1);
    for (int i = 0; i < FRAME; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    chk("ovf_hold", 32'(bus.out_byte), 32'hA5);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_drain", 32'(bus.out_valid), 32'd0);
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);

    // gaps between every bit
    do_reset();
    send_zeros(L, 2, 1'b1);
    send_a5(8, 2, 1'b1, 1'b1);
    chk("gap_byte",  32'(bus.out_byte),  32'hA5);
    chk("gap_valid", 32'(bus.out_valid), 32'd1);

    // reset mid-byte, then replay
    do_reset();
    send_zeros(L, 0, 1'b0);
    send_a5(4, 0, 1'b0, 1'b1);
    do_reset();
    send_zeros(L, 0, 1'b1);
    send_a5(8, 0, 1'b1, 1'b1);
    chk("replay_byte", 32'(bus.out_byte), 32'hA5);
    chk("replay_ovf",  32'(bus.overflow), 32'd0);

`ifdef DESCRAMBLER_PARITY_EN
    // corrupted parity bit still delivers the byte
    do_reset();
    send_zeros(L, 0, 1'b1);
    send_a5(8, 0, 1'b1, 1'b0);
    chk("par_bad_err",  32'(bus.parity_err), 32'd1);
    chk("par_bad_byte", 32'(bus.out_byte),   32'hA5);
`endif

    // random traffic with occasional resets
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 499) == 0),
           ($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
